// File: rtl/axis_fifo_pkt_if.sv
// AXI4-Stream bundle shared by the FIFO's upstream (slave) and downstream (master) sides.
// Sideband fields are always present; the FIFO decides which of them it actually carries.
interface axis_fifo_pkt_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 1
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tValid;
  logic              tReady;
  logic [DATA_W-1:0] tData;
  logic [KEEP_W-1:0] tStrb;
  logic [KEEP_W-1:0] tKeep;
  logic              tLast;
  logic [ID_W-1:0]   tId;
  logic [DEST_W-1:0] tDest;
  logic [USER_W-1:0] tUser;

  modport master (
    output tValid, tData, tStrb, tKeep, tLast, tId, tDest, tUser,
    input  tReady
  );

  modport slave (
    input  tValid, tData, tStrb, tKeep, tLast, tId, tDest, tUser,
    output tReady
  );
endinterface

// File: rtl/axis_fifo_pkt.sv
// AXI4-Stream FIFO with optional sideband storage and optional store-and-forward packet mode.
// Output valid lags a write by one extra cycle so it never depends on the same-cycle write.
module axis_fifo_pkt #(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int DEST_W      = 4,
  parameter int USER_W      = 1,
  parameter int DEPTH       = 16,
  parameter bit TKEEP_EN    = 1'b1,
  parameter bit TSTRB_EN    = 1'b0,
  parameter bit TLAST_EN    = 1'b1,
  parameter bit TID_EN      = 1'b0,
  parameter bit TDEST_EN    = 1'b0,
  parameter bit TUSER_EN    = 1'b0,
  parameter bit PACKET_MODE = 1'b0,
  localparam int KEEP_W = DATA_W / 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  axis_fifo_pkt_if.slave   s,
  axis_fifo_pkt_if.master  m,
  output logic [CNT_W-1:0] LEVEL,
  output logic [CNT_W-1:0] PKT_CNT,
  output logic             OVERSIZE
);

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  level_q, level_d, pktCnt_q, pktCnt_d;
  logic [CNT_W-1:0]  avail, pktAvail;
  logic              sReady_q, sReady_d, mValid_q, mValid_d;
  logic              release_q, release_d, oversize_q, oversize_d;
  logic              wrEn, rdEn, inLast, outLast, wrLast, rdLast;
  logic [KEEP_W-1:0] keepOut;
  logic [DATA_W-1:0] dataMem [DEPTH];

  if (PACKET_MODE && !TLAST_EN) begin : gBadCfg
    $error("axis_fifo_pkt: PACKET_MODE requires TLAST_EN");
  end

  assign wrEn   = s.tValid && sReady_q;
  assign rdEn   = mValid_q && m.tReady;
  assign wrLast = wrEn && inLast;
  assign rdLast = rdEn && outLast;

  always_ff @(posedge ACLK) begin
    if (wrEn) dataMem[wrPtr_q] <= s.tData;
  end
  assign m.tData = dataMem[rdPtr_q];

  if (TKEEP_EN) begin : gKeep
    logic [KEEP_W-1:0] keepMem [DEPTH];
    always_ff @(posedge ACLK) begin
      if (wrEn) keepMem[wrPtr_q] <= s.tKeep;
    end
    assign keepOut = keepMem[rdPtr_q];
  end else begin : gNoKeep
    logic unusedKeep;
    assign unusedKeep = ^s.tKeep;
    assign keepOut    = '1;
  end
  assign m.tKeep = keepOut;

  // A disabled strobe mirrors whatever keep is presented, stored or defaulted.
  if (TSTRB_EN) begin : gStrb
    logic [KEEP_W-1:0] strbMem [DEPTH];
    always_ff @(posedge ACLK) begin
      if (wrEn) strbMem[wrPtr_q] <= s.tStrb;
    end
    assign m.tStrb = strbMem[rdPtr_q];
  end else begin : gNoStrb
    logic unusedStrb;
    assign unusedStrb = ^s.tStrb;
    assign m.tStrb    = keepOut;
  end

  if (TLAST_EN) begin : gLast
    logic lastMem [DEPTH];
    always_ff @(posedge ACLK) begin
      if (wrEn) lastMem[wrPtr_q] <= s.tLast;
    end
    assign inLast  = s.tLast;
    assign outLast = lastMem[rdPtr_q];
  end else begin : gNoLast
    logic unusedLast;
    assign unusedLast = s.tLast;
    assign inLast     = 1'b1;
    assign outLast    = 1'b1;
  end
  assign m.tLast = outLast;

  if (TID_EN) begin : gId
    logic [ID_W-1:0] idMem [DEPTH];
    always_ff @(posedge ACLK) begin
      if (wrEn) idMem[wrPtr_q] <= s.tId;
    end
    assign m.tId = idMem[rdPtr_q];
  end else begin : gNoId
    logic unusedId;
    assign unusedId = ^s.tId;
    assign m.tId    = '0;
  end

  if (TDEST_EN) begin : gDest
    logic [DEST_W-1:0] destMem [DEPTH];
    always_ff @(posedge ACLK) begin
      if (wrEn) destMem[wrPtr_q] <= s.tDest;
    end
    assign m.tDest = destMem[rdPtr_q];
  end else begin : gNoDest
    logic unusedDest;
    assign unusedDest = ^s.tDest;
    assign m.tDest    = '0;
  end

  if (TUSER_EN) begin : gUser
    logic [USER_W-1:0] userMem [DEPTH];
    always_ff @(posedge ACLK) begin
      if (wrEn) userMem[wrPtr_q] <= s.tUser;
    end
    assign m.tUser = userMem[rdPtr_q];
  end else begin : gNoUser
    logic unusedUser;
    assign unusedUser = ^s.tUser;
    assign m.tUser    = '0;
  end

  // avail/pktAvail exclude beats written on this edge, giving the one-cycle valid lag.
  always_comb begin
    wrPtr_d    = wrPtr_q + PTR_W'(wrEn);
    rdPtr_d    = rdPtr_q + PTR_W'(rdEn);
    level_d    = level_q + CNT_W'(wrEn) - CNT_W'(rdEn);
    pktCnt_d   = pktCnt_q + CNT_W'(wrLast) - CNT_W'(rdLast);
    avail      = level_q - CNT_W'(rdEn);
    pktAvail   = pktCnt_q - CNT_W'(rdLast);
    oversize_d = PACKET_MODE && !release_q && (level_q == CNT_W'(DEPTH)) && (pktCnt_q == '0);
    release_d  = release_q;
    if (release_q && rdLast) release_d = 1'b0;
    else if (oversize_d)     release_d = 1'b1;
    mValid_d   = (avail != '0) && (!PACKET_MODE || (pktAvail != '0) || release_d);
    sReady_d   = level_d < CNT_W'(DEPTH);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      pktCnt_q   <= '0;
      sReady_q   <= 1'b0;
      mValid_q   <= 1'b0;
      release_q  <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      pktCnt_q   <= pktCnt_d;
      sReady_q   <= sReady_d;
      mValid_q   <= mValid_d;
      release_q  <= release_d;
      oversize_q <= oversize_d;
    end
  end

  assign s.tReady = sReady_q;
  assign m.tValid = mValid_q;
  assign LEVEL    = level_q;
  assign PKT_CNT  = pktCnt_q;
  assign OVERSIZE = oversize_q;

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Directed bench for axis_fifo_pkt: four instances cover flow-through, packet mode at two depths
// and disabled sideband pins; inputs change and outputs are sampled on the falling edge.
module tb_axis_fifo_pkt;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  axis_fifo_pkt_if aS (), aM (), qS (), qM (), pS (), pM (), dS (), dM ();

  logic [2:0] aLevel, aPkt, pLevel, pPkt, dLevel, dPkt;
  logic [4:0] qLevel, qPkt;
  logic       aOver, qOver, pOver, dOver;

  axis_fifo_pkt #(.DEPTH(4)) dutA (
    .ACLK(ACLK), .ARESETn(ARESETn), .s(aS), .m(aM),
    .LEVEL(aLevel), .PKT_CNT(aPkt), .OVERSIZE(aOver)
  );

  axis_fifo_pkt #(.DEPTH(16), .PACKET_MODE(1'b1)) dutQ (
    .ACLK(ACLK), .ARESETn(ARESETn), .s(qS), .m(qM),
    .LEVEL(qLevel), .PKT_CNT(qPkt), .OVERSIZE(qOver)
  );

  axis_fifo_pkt #(.DEPTH(4), .PACKET_MODE(1'b1)) dutP (
    .ACLK(ACLK), .ARESETn(ARESETn), .s(pS), .m(pM),
    .LEVEL(pLevel), .PKT_CNT(pPkt), .OVERSIZE(pOver)
  );

  axis_fifo_pkt #(.DEPTH(4), .TKEEP_EN(1'b0), .TSTRB_EN(1'b0), .TID_EN(1'b0), .TLAST_EN(1'b0)) dutD (
    .ACLK(ACLK), .ARESETn(ARESETn), .s(dS), .m(dM),
    .LEVEL(dLevel), .PKT_CNT(dPkt), .OVERSIZE(dOver)
  );

  int  wrIdx, rdIdx, bubbles, firstCyc, overCnt;
  int  levelAtOver;
  bit  started, wrOk;

  // Advances one full clock with the currently driven inputs, returning on the falling edge.
  task automatic applyStimulus();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    {aS.tValid, aS.tData, aS.tStrb, aS.tKeep, aS.tLast, aS.tId, aS.tDest, aS.tUser} = '0;
    {qS.tValid, qS.tData, qS.tStrb, qS.tKeep, qS.tLast, qS.tId, qS.tDest, qS.tUser} = '0;
    {pS.tValid, pS.tData, pS.tStrb, pS.tKeep, pS.tLast, pS.tId, pS.tDest, pS.tUser} = '0;
    {dS.tValid, dS.tData, dS.tStrb, dS.tKeep, dS.tLast, dS.tId, dS.tDest, dS.tUser} = '0;
    aM.tReady = 1'b0;
    qM.tReady = 1'b0;
    pM.tReady = 1'b0;
    dM.tReady = 1'b0;

    // Reset state
    repeat (2) @(negedge ACLK);
    checkOutput("rst sReady", aS.tReady, 0);
    checkOutput("rst mValid", aM.tValid, 0);
    checkOutput("rst level", aLevel, 0);
    checkOutput("rst pktCnt", aPkt, 0);
    checkOutput("rst oversize", pOver, 0);
    checkOutput("rst q oversize", qOver, 0);
    checkOutput("rst d oversize", dOver, 0);
    ARESETn = 1'b1;
    applyStimulus();
    checkOutput("post-rst sReady", aS.tReady, 1);
    checkOutput("post-rst p sReady", pS.tReady, 1);

    // Fill DEPTH=4 with downstream stalled, then drain
    $display("[TB] flow-through fill/drain");
    for (int i = 0; i < 4; i++) begin
      aS.tValid = 1'b1;
      aS.tData  = 32'hA0 + i;
      aS.tKeep  = 4'(i + 1);
      aS.tLast  = (i == 1 || i == 3);
      applyStimulus();
      if (i == 0) begin
        checkOutput("first beat latency mValid", aM.tValid, 0);
        checkOutput("first beat level", aLevel, 1);
      end
    end
    aS.tValid = 1'b0;
    checkOutput("full level", aLevel, 4);
    checkOutput("full sReady", aS.tReady, 0);
    checkOutput("full pktCnt", aPkt, 2);
    checkOutput("full mValid", aM.tValid, 1);
    applyStimulus();
    checkOutput("stall hold mValid", aM.tValid, 1);
    checkOutput("stall hold data", aM.tData, 32'hA0);
    aM.tReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain data", aM.tData, 32'hA0 + i);
      checkOutput("drain keep", aM.tKeep, 4'(i + 1));
      checkOutput("drain last", aM.tLast, (i == 1 || i == 3));
      applyStimulus();
    end
    checkOutput("drained level", aLevel, 0);
    checkOutput("drained mValid", aM.tValid, 0);
    checkOutput("drained sReady", aS.tReady, 1);
    checkOutput("drained pktCnt", aPkt, 0);

    // 100 back-to-back beats with the sink always ready
    $display("[TB] continuous stream");
    wrIdx = 0; rdIdx = 0; bubbles = 0; started = 1'b0; firstCyc = -1;
    aS.tKeep = 4'hF;
    aS.tLast = 1'b0;
    for (int cyc = 0; cyc < 130 && rdIdx < 100; cyc++) begin
      aS.tValid = (wrIdx < 100);
      aS.tData  = 32'hB000_0000 + wrIdx;
      if (aM.tValid) begin
        if (!started) firstCyc = cyc;
        started = 1'b1;
        checkOutput("stream data", aM.tData, 32'hB000_0000 + rdIdx);
        rdIdx++;
      end else if (started) begin
        bubbles++;
      end
      wrOk = aS.tValid && aS.tReady;
      applyStimulus();
      if (wrOk) wrIdx++;
    end
    aS.tValid = 1'b0;
    checkOutput("stream beats read", rdIdx, 100);
    checkOutput("stream bubbles", bubbles, 0);
    checkOutput("stream first valid cycle", firstCyc, 2);
    checkOutput("stream level end", aLevel, 0);

    // Packet mode DEPTH=16: nothing leaves until TLAST is stored
    $display("[TB] packet mode 3-beat packet");
    qM.tReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      qS.tValid = 1'b1;
      qS.tData  = 32'hC0 + i;
      qS.tLast  = (i == 2);
      applyStimulus();
      checkOutput("pkt3 mValid before release", qM.tValid, 0);
    end
    qS.tValid = 1'b0;
    checkOutput("pkt3 pktCnt", qPkt, 1);
    applyStimulus();
    checkOutput("pkt3 mValid rises", qM.tValid, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("pkt3 data", qM.tData, 32'hC0 + i);
      checkOutput("pkt3 last", qM.tLast, (i == 2));
      applyStimulus();
    end
    checkOutput("pkt3 pktCnt after", qPkt, 0);
    checkOutput("pkt3 mValid after", qM.tValid, 0);
    checkOutput("pkt3 level after", qLevel, 0);

    // Packet mode DEPTH=4: 6-beat packet forces cut-through release
    $display("[TB] packet mode oversize packet");
    wrIdx = 0; rdIdx = 0; overCnt = 0; levelAtOver = -1;
    pM.tReady = 1'b1;
    for (int cyc = 0; cyc < 40 && rdIdx < 6; cyc++) begin
      pS.tValid = (wrIdx < 6);
      pS.tData  = 32'hD0 + wrIdx;
      pS.tLast  = (wrIdx == 5);
      if (pOver) begin
        overCnt++;
        levelAtOver = int'(pLevel);
      end
      if (pM.tValid) begin
        checkOutput("oversize data", pM.tData, 32'hD0 + rdIdx);
        rdIdx++;
      end
      wrOk = pS.tValid && pS.tReady;
      applyStimulus();
      if (wrOk) wrIdx++;
    end
    pS.tValid = 1'b0;
    checkOutput("oversize beats read", rdIdx, 6);
    checkOutput("oversize pulses", overCnt, 1);
    checkOutput("oversize level at pulse", levelAtOver, 4);
    checkOutput("oversize mValid end", pM.tValid, 0);
    checkOutput("oversize level end", pLevel, 0);
    pS.tValid = 1'b1;
    pS.tData  = 32'hE7;
    pS.tLast  = 1'b0;
    applyStimulus();
    pS.tValid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("release cleared mValid", pM.tValid, 0);
    checkOutput("release cleared level", pLevel, 1);
    pS.tValid = 1'b1;
    pS.tData  = 32'hE8;
    pS.tLast  = 1'b1;
    applyStimulus();
    pS.tValid = 1'b0;
    applyStimulus();
    checkOutput("next packet mValid", pM.tValid, 1);
    checkOutput("next packet data", pM.tData, 32'hE7);
    applyStimulus();
    applyStimulus();
    checkOutput("next packet drained", pLevel, 0);

    // Disabled sideband pins are driven with defaults regardless of input
    $display("[TB] disabled sideband defaults");
    dM.tReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dS.tValid = 1'b1;
      dS.tData  = 32'h5A00 + i;
      dS.tKeep  = 4'($urandom);
      dS.tStrb  = 4'($urandom);
      dS.tId    = 4'($urandom);
      dS.tDest  = 4'($urandom);
      dS.tUser  = 1'($urandom);
      dS.tLast  = 1'($urandom);
      applyStimulus();
    end
    dS.tValid = 1'b0;
    checkOutput("disabled level", dLevel, 4);
    dM.tReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("disabled data", dM.tData, 32'h5A00 + i);
      checkOutput("disabled keep", dM.tKeep, 4'hF);
      checkOutput("disabled strb", dM.tStrb, 4'hF);
      checkOutput("disabled id", dM.tId, 0);
      checkOutput("disabled dest", dM.tDest, 0);
      checkOutput("disabled user", dM.tUser, 0);
      checkOutput("disabled last", dM.tLast, 1);
      applyStimulus();
    end
    checkOutput("disabled drained", dLevel, 0);
    checkOutput("disabled pktCnt drained", dPkt, 0);

    // Asynchronous reset with three beats stored
    $display("[TB] reset mid-stream");
    aM.tReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      aS.tValid = 1'b1;
      aS.tData  = 32'hE0 + i;
      aS.tLast  = (i == 2);
      applyStimulus();
    end
    aS.tValid = 1'b0;
    checkOutput("pre-reset level", aLevel, 3);
    checkOutput("pre-reset pktCnt", aPkt, 1);
    checkOutput("pre-reset mValid", aM.tValid, 1);
    #2 ARESETn = 1'b0;
    #1;
    checkOutput("async rst mValid", aM.tValid, 0);
    checkOutput("async rst sReady", aS.tReady, 0);
    checkOutput("async rst level", aLevel, 0);
    checkOutput("async rst pktCnt", aPkt, 0);
    @(negedge ACLK);
    ARESETn   = 1'b1;
    aS.tValid = 1'b1;
    aS.tData  = 32'hF0;
    aS.tLast  = 1'b0;
    applyStimulus();
    checkOutput("post-reset sReady", aS.tReady, 1);
    checkOutput("post-reset level empty", aLevel, 0);
    applyStimulus();
    aS.tValid = 1'b0;
    applyStimulus();
    checkOutput("post-reset first read valid", aM.tValid, 1);
    checkOutput("post-reset first read data", aM.tData, 32'hF0);
    checkOutput("post-reset level", aLevel, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
